// File: rtl/uart_tx_fifo_if.sv
// Minimal AXI4-Stream link: only tdata/tvalid/tready are carried.
interface taxi_axis_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport src (output tdata, output tvalid, input tready);
  modport snk (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// FWFT byte FIFO feeding the UART transmitter: a byte pushed at edge N is presented from cycle N+1.
// Backpressure: tready drops when full or disabled; tvalid drops when empty or disabled; flush empties in one cycle.
module uart_tx_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             flush,
  taxi_axis_if.snk         s_axis,
  taxi_axis_if.src         m_axis,
  input  logic [LVL_W-1:0] low_thresh,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             low_water,
  output logic             drained
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // The extra pointer MSB lets level reach DEPTH without aliasing to empty.
  assign level     = LVL_W'(wr_ptr - rd_ptr);
  assign full      = (level == LVL_W'(DEPTH));
  assign empty     = (level == '0);
  assign low_water = (level <= low_thresh);

  assign s_axis.tready = En && !full;
  assign m_axis.tvalid = En && !empty;
  assign m_axis.tdata  = mem[rd_ptr[ADDR_W-1:0]];

  assign push = s_axis.tvalid && s_axis.tready;
  assign pop  = m_axis.tvalid && m_axis.tready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      drained <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      drained <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      drained <= pop && !push && (level == LVL_W'(1));
    end
  end

  // Contents are never reset; only handshakes that survive reset/flush are written.
  always_ff @(posedge Clk) begin
    if (push && !flush && !Rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= s_axis.tdata;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer directly upstream of the UART transmitter.
- Accepts bytes over AXI4-Stream from the register/AES side and presents them FWFT over AXI4-Stream to the transmitter's sink port.
- Provides fill level, low-watermark and drain-complete status for interrupt generation.
- Supports a single-cycle flush.

Parameters:
- DEPTH, 16: number of byte entries; power of two, >= 2.
- DATA_W, 8: tdata width of both stream ports.
- LVL_W, $clog2(DEPTH+1): width of level and threshold signals (derived, not to be overridden).

Ports:
- Clk, input, 1: clock.
- Rst, input, 1: reset, synchronous, active-high.
- En, input, 1: block enable; low gates both handshakes, contents retained.
- flush, input, 1: discard all contents.
- s_axis, taxi_axis_if.snk, DATA_W: byte input; only tdata/tvalid/tready used.
- m_axis, taxi_axis_if.src, DATA_W: byte output to transmitter; only tdata/tvalid/tready driven/used.
- low_thresh, input, LVL_W: low-watermark threshold.
- level, output, LVL_W: current occupancy, 0..DEPTH.
- full, output, 1: level == DEPTH.
- empty, output, 1: level == 0.
- low_water, output, 1: level <= low_thresh.
- drained, output, 1: one-cycle pulse when the last byte is popped.

Behaviour:
- Storage:
  - DEPTH x DATA_W array; no reset of array contents.
  - wr_ptr and rd_ptr are ADDR_W+1 bits (ADDR_W = log2 DEPTH); the MSB disambiguates full vs empty.
  - Pointers wrap naturally at 2*DEPTH.
  - level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Push: s_axis.tready = En && !full, from registered state only. Push occurs when tvalid && tready.
- Pop:
  - m_axis.tvalid = En && !empty.
  - m_axis.tdata = mem[rd_ptr[ADDR_W-1:0]], combinational (FWFT).
  - Pop occurs when tvalid && tready.
- Latency:
  - Byte pushed at edge N is visible on m_axis from cycle N+1.
  - No empty bypass: tvalid is never asserted in the same cycle as the first push.
- Simultaneous push and pop:
  - Both occur; level unchanged; pointers each advance by 1.
  - When full, tready is 0, so a same-cycle pop does not admit a push; the push is admitted the next cycle.
- Ordering: strict FIFO; a byte is popped exactly once.
- level, full, empty, low_water:
  - Derived from registered pointers and updated the cycle after the handshake edge.
  - low_water is combinational from level and low_thresh.
  - low_thresh >= DEPTH makes low_water permanently 1.
- drained:
  - Registered one-cycle pulse in the cycle after a pop that takes level from 1 to 0 without a simultaneous push.
  - Not asserted on flush or reset.
- flush:
  - Synchronous; at the edge, rd_ptr <= wr_ptr, i.e. empty next cycle.
  - A push or pop handshaking in the same cycle as flush is discarded; flush wins.
  - tready and tvalid are not gated by flush in the flush cycle itself.
- En:
  - En low forces s_axis.tready = 0 and m_axis.tvalid = 0.
  - Pointers, contents and level are held; level/full/empty/low_water remain valid.
  - Resuming En restores output of the oldest byte.
  - flush still acts while En is low.
- Reset: Rst has priority over flush and En. At the edge:
  - wr_ptr = rd_ptr = 0, drained = 0.
  - Outputs after reset: level = 0, empty = 1, full = 0, s_axis.tready = En, m_axis.tvalid = 0, low_water = 1.
  - Reset mid-transfer loses all buffered bytes without a drained pulse.
- Pointer wrap: full, empty and level must stay correct across any number of wrap-arounds, including when wr_ptr and rd_ptr sit in different MSB halves.

Test Plan:
- Reset, DEPTH=16: after Rst, expect level=0, empty=1, low_water=1 (low_thresh=4), m_axis.tvalid=0. Push 0xA5 -> tvalid=1 next cycle with tdata=0xA5, level=1.
- Fill with m_axis.tready=0: push 0x00..0x0F -> full=1, tready=0 after the 16th. A 17th byte is held on the sink and not accepted. Then pop all -> order 0x00..0x0F; drained pulses once, one cycle after the 16th pop.
- Full with simultaneous push/pop: tready=1 on m_axis while the sink holds tvalid -> that cycle pops 0x00 and accepts nothing. The next cycle accepts the new byte; level 16->15->16.
- Streaming wrap: continuous push/pop of 40 bytes (0x30..0x57) with m_axis.tready toggling every cycle -> output sequence identical, no gaps while non-empty; level never exceeds 16 or underflows; full/empty correct after pointer wrap.
- Watermark: low_thresh=4, push 6 bytes -> low_water=0 at level 5. Pop 2 -> low_water=1 when level=4.
- Flush and En:
  - With 5 bytes stored, drop En -> tvalid=0 and tready=0, level=5 held; raise En -> oldest byte presented.
  - Assert flush concurrent with a push -> next cycle empty=1, level=0, pushed byte discarded, no drained pulse.
